// File: rtl/pc_unit.sv
// Fetch-stage program counter for the pipelined WISC core: sequential/B/BR
// next-PC selection, stall hold, late-stage redirect and a squashable halt.
module pc_unit #(
  parameter int                  PC_WIDTH          = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR      = '0,
  parameter bit                  HALT_NEEDS_COMMIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         instruction,
  input  logic [PC_WIDTH-1:0] branch_reg_val,
  input  logic [2:0]          flags,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt_commit,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus_two,
  output logic                branch_taken,
  output logic                halted
);

  typedef enum logic [1:0] {
    RUN          = 2'b00,
    HALT_PENDING = 2'b01,
    HALTED       = 2'b10
  } state_t;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // flags arrive as {N, Z, V}
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] nzv);
    logic n, z, v;
    n = nzv[2];
    z = nzv[1];
    v = nzv[0];
    case (cond)
      3'd0:    cond_met = ~z;
      3'd1:    cond_met = z;
      3'd2:    cond_met = ~z & ~n;
      3'd3:    cond_met = n;
      3'd4:    cond_met = z | (~z & ~n);
      3'd5:    cond_met = n | z;
      3'd6:    cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  state_t                     state_p0, state_nxt;
  logic [PC_WIDTH-1:0]        pc_p0, pc_nxt;
  logic                       halted_p0;

  logic [3:0]                 opcode;
  logic signed [8:0]          offset;
  logic signed [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0]        b_target;
  logic [PC_WIDTH-1:0]        branch_target;
  logic                       is_branch;

  assign opcode      = instruction[15:12];
  assign offset      = instruction[8:0];
  assign offset_ext  = PC_WIDTH'(offset);
  assign pc_plus_two = pc_p0 + PC_WIDTH'(2);

  // Word offset: the shifted sign-extended value wraps with the PC sum.
  assign b_target      = pc_plus_two + $unsigned(offset_ext <<< 1);
  assign branch_target = (opcode == OP_B) ? b_target : branch_reg_val;
  assign is_branch     = (opcode == OP_B) || (opcode == OP_BR);

  assign branch_taken = (state_p0 == RUN) & ~stall & ~redirect_valid & is_branch &
                        cond_met(instruction[11:9], flags);

  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    if (state_p0 == HALTED) begin
      state_nxt = HALTED;
    end else if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      state_nxt = RUN;
    end else if (state_p0 == HALT_PENDING) begin
      if (halt_commit) state_nxt = HALTED;
    end else if (stall) begin
      state_nxt = state_p0;
    end else if (opcode == OP_HLT) begin
      state_nxt = HALT_NEEDS_COMMIT ? HALT_PENDING : HALTED;
    end else if (branch_taken) begin
      pc_nxt = branch_target;
    end else begin
      pc_nxt = pc_plus_two;
    end
  end

  // ---- stage p0: fetch PC and halt state registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0  <= RUN;
      pc_p0     <= RESET_VECTOR;
      halted_p0 <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      pc_p0     <= pc_nxt;
      halted_p0 <= (state_nxt == HALTED);
    end
  end

  assign pc     = pc_p0;
  assign halted = halted_p0;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-cycle PC register: fetch-stage program counter for the pipelined WISC core.
- Computes the next PC from the fetched instruction: B, BR, HLT, or sequential.
- Adds fetch-stall hold, redirect from a later pipeline stage, and a configurable halt state machine so a speculatively fetched HLT can be squashed.
- Feeds the instruction memory address and the pc_plus_two value used by PCS.

Parameters:
- PC_WIDTH, 16, width of pc, branch_reg_val, redirect_pc and pc_plus_two (min 10).
- RESET_VECTOR, 0, PC value loaded on reset; must be even.
- HALT_NEEDS_COMMIT, 1:
  - 1: a fetched HLT parks in HALT_PENDING until halt_commit.
  - 0: a fetched HLT goes straight to HALTED, giving single-cycle-compatible behaviour.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instruction  in  16  instruction fetched at the current pc; [15:12] opcode, [11:9] condition, [8:0] signed word offset.
- branch_reg_val  in  PC_WIDTH  register-file value for BR targets.
- flags  in  3  {N, Z, V} from the flag register.
- stall  in  1  hold pc; fetch is stalled.
- redirect_valid  in  1  later stage demands a fetch restart.
- redirect_pc  in  PC_WIDTH  restart address, used unaltered.
- halt_commit  in  1  HLT has reached writeback; ignored unless in HALT_PENDING.
- pc  out  PC_WIDTH  current fetch address (registered).
- pc_plus_two  out  PC_WIDTH  pc + 2 modulo 2^PC_WIDTH (combinational).
- branch_taken  out  1  fetch-stage branch redirect this cycle (combinational).
- halted  out  1  high when state is HALTED (registered).

Behaviour:
- Reset (rst_n low at posedge): pc = RESET_VECTOR, state = RUN, halted = 0. Reset overrides every other input, including mid-halt and mid-stall.
- States: RUN, HALT_PENDING, HALTED (2-bit encoding).
- Condition met, indexed by cond:
  - 0: ~Z
  - 1: Z
  - 2: ~Z & ~N
  - 3: N
  - 4: Z | (~Z & ~N)
  - 5: N | Z
  - 6: V
  - 7: 1
- B target: pc_plus_two + (sign-extend(offset[8:0]) << 1), truncated to PC_WIDTH (wraps).
- BR target: branch_reg_val unaltered.
- branch_taken = (state == RUN) & ~stall & ~redirect_valid & (opcode == 0xC or 0xD) & condition met.
- Next-state priority, highest first:
  1. Reset.
  2. State HALTED: pc holds; stall, redirect_valid and halt_commit are all ignored.
  3. redirect_valid in RUN or HALT_PENDING: pc <= redirect_pc; state <= RUN.
  4. State HALT_PENDING:
     - halt_commit: state <= HALTED, pc holds.
     - otherwise: pc holds, stay in HALT_PENDING.
  5. stall in RUN: pc holds, state holds. An HLT presented under stall is not acted on.
  6. Opcode 0xF in RUN: pc holds. State <= HALT_PENDING if HALT_NEEDS_COMMIT is 1, else HALTED.
  7. branch_taken: pc <= target.
  8. Otherwise: pc <= pc_plus_two, wrapping to 0 past 2^PC_WIDTH - 2.
- Latency: new pc is visible one cycle after the deciding edge.
- pc_plus_two tracks pc combinationally in every state.
- halted rises on the edge that enters HALTED and stays high until reset.
- Opcode 0xE (PCS) and all other opcodes are sequential.
- A not-taken B or BR is sequential.
- Simultaneous redirect_valid and halt_commit in HALT_PENDING: redirect wins and halt_commit is dropped.

Test Plan:
1. Reset then ADD stream:
   - rst_n low 20 cycles, then high with instruction 0x0000.
   - pc reads 0x0000 after reset, then 0x0002, 0x0004, ... for 2000 cycles.
   - pc_plus_two == pc + 2 on every cycle.
2. Branch sweep:
   - B instruction 0xC3FF (cond 1, offset -1) at pc 0x0010, flags Z=1: pc becomes 0x0010 and branch_taken = 1.
   - Same instruction with Z=0: pc becomes 0x0012.
   - BR 0xDE00 (cond 7) with branch_reg_val 0x1234: pc becomes 0x1234.
   - Also sweep all 8 conditions x 8 flag values against the condition table.
3. Stall and redirect:
   - stall high for 5 cycles with B taken: pc unchanged and branch_taken = 0 throughout.
   - redirect_valid with redirect_pc 0x0400 while stall is high: pc becomes 0x0400.
4. Squashed HLT (HALT_NEEDS_COMMIT=1):
   - Fetch 0xF000 at 0x0020: pc holds at 0x0020 and halted = 0.
   - 3 cycles later, redirect to 0x0040: pc becomes 0x0040, state RUN, pc increments to 0x0042 next cycle.
5. Committed HLT:
   - HLT then halt_commit: halted = 1 on the next edge.
   - 2000 cycles of random instruction, redirect_valid and stall: pc frozen, halted stays 1.
   - rst_n low: pc becomes RESET_VECTOR and halted = 0.
6. Direct halt and wrap (HALT_NEEDS_COMMIT=0, PC_WIDTH=10, RESET_VECTOR=0x3FC):
   - Sequential instructions: pc steps 0x3FC, 0x3FE, then wraps to 0x000.
   - HLT: halted = 1 on the next edge, with no halt_commit needed.
